i2s_rx_fifo: RTL and testbench

Parametrised I2S master receiver, successor to the single-word `i2s` block. It generates BCLK and WS from the system clock and deserialises stereo or mono samples of configurable width. Samples go into an internal FIFO with a first-word-fall-through read port. It sits between the external MEMS microphone and the DMA/bus-side reader.

---
 rtl/i2s_rx_fifo.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2s_rx_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_fifo.sv
// ---------------------------------------------------------------------------
// i2s_rx_fifo
// I2S master receiver with a first-word-fall-through sample FIFO.
// Derives BCLK/WS from clk, deserialises left (and optionally right) slot
// samples MSB first, and queues them as {channel, data} for a bus-side reader.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   en             1 = run bit clock and capture, 0 = idle (FIFO kept)
//   stereo         1 = capture left+right, 0 = left only (taken at frame start)
//   WS, BCLK       I2S word select / bit clock outputs
//   DIN            serial data from the slave
//   done           one-cycle pulse per completed sample (also when dropped)
//   rd_en          pop the head entry
//   rd_data, rd_ch head sample (right-aligned) and its channel; 0 when empty
//   empty, full    FIFO status
//   level          FIFO entry count
//   overflow       sticky drop flag, cleared by ovf_clr (a new drop wins)
//
// Build option
//   I2S_RX_SIGN_EXT_EN  defined: samples sign-extended from bit SAMPLE_W-1;
//                       undefined: samples zero-extended.
//
// Sequencer states
//   state   | meaning
//   ST_IDLE | en low: clocks parked low, counters cleared
//   ST_SYNC | first BCLK high phase after en rises; fc=0 bit has no owner
//   ST_RUN  | free-running frames; fc=0 bit is the last right-slot bit
// ---------------------------------------------------------------------------
module i2s_rx_fifo #(
  parameter int CLK_DIV    = 4,
  parameter int SLOT_W     = 32,
  parameter int SAMPLE_W   = 24,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          stereo,
  output logic                          WS,
  output logic                          BCLK,
  input  logic                          DIN,
  output logic                          done,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_ch,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int FC_W  = $clog2(2 * SLOT_W);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                bclk_q, bclk_d;
  logic                ws_q, ws_d;
  logic [FC_W-1:0]     fc_q, fc_d;
  logic                stereo_q, stereo_d;
  logic [SAMPLE_W-1:0] sr_q, sr_d;
  logic                pend_q, pend_d;
  logic                pend_ch_q, pend_ch_d;

  logic [DATA_W:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic                ovf_q, ovf_d;

  logic                bclk_tick, bclk_rise, bclk_fall;
  logic [FC_W-1:0]     fc_inc;
  logic                bit_vld, bit_ch;
  logic [FC_W-1:0]     bit_idx;
  logic                cap;
  logic [DATA_W-1:0]   push_data;
  logic                fifo_empty, fifo_full, pop, wr, drop;

  // ---------------- sequencer ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!en)            state_d = ST_IDLE;
        else if (bclk_fall) state_d = ST_RUN;
      end
      ST_RUN:  if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- clock generation and bit decode ----------------
  assign bclk_tick = en && (div_q == DIV_W'(CLK_DIV - 1));
  assign bclk_rise = bclk_tick && !bclk_q;
  assign bclk_fall = bclk_tick && bclk_q;
  assign fc_inc    = (fc_q == FC_W'(2 * SLOT_W - 1)) ? '0 : fc_q + FC_W'(1);

  // Left slot owns fc=1..SLOT_W; right slot owns the rest of the frame plus
  // fc=0 of the following frame (one-bit I2S delay).
  always_comb begin
    bit_vld = 1'b0;
    bit_ch  = 1'b0;
    bit_idx = '0;
    if (fc_q >= FC_W'(1) && fc_q <= FC_W'(SLOT_W)) begin
      bit_vld = 1'b1;
      bit_idx = fc_q - FC_W'(1);
    end else if (fc_q > FC_W'(SLOT_W)) begin
      bit_vld = 1'b1;
      bit_ch  = 1'b1;
      bit_idx = fc_q - FC_W'(SLOT_W + 1);
    end else begin
      bit_vld = (state_q == ST_RUN);
      bit_ch  = 1'b1;
      bit_idx = FC_W'(SLOT_W - 1);
    end
  end

  assign cap = bclk_rise && bit_vld && (bit_idx < FC_W'(SAMPLE_W)) && (!bit_ch || stereo_q);

  always_comb begin
    div_d     = div_q;
    bclk_d    = bclk_q;
    ws_d      = ws_q;
    fc_d      = fc_q;
    stereo_d  = stereo_q;
    sr_d      = sr_q;
    pend_d    = 1'b0;
    pend_ch_d = pend_ch_q;
    if (!en) begin
      div_d    = '0;
      bclk_d   = 1'b0;
      ws_d     = 1'b0;
      fc_d     = '0;
      stereo_d = stereo;
    end else begin
      div_d = bclk_tick ? '0 : div_q + DIV_W'(1);
      if (bclk_tick) bclk_d = !bclk_q;
      if (bclk_fall) begin
        fc_d = fc_inc;
        ws_d = (fc_inc >= FC_W'(SLOT_W));
        // Channel mode is frozen when the left MSB slot begins so that the
        // right slot (which spills into the next frame) stays consistent.
        if (fc_inc == FC_W'(1)) stereo_d = stereo;
      end
      if (cap) begin
        sr_d = (sr_q << 1) | SAMPLE_W'(DIN);
        if (bit_idx == FC_W'(SAMPLE_W - 1)) begin
          pend_d    = 1'b1;
          pend_ch_d = bit_ch;
        end
      end
    end
  end

  // ---------------- FIFO ----------------
`ifdef I2S_RX_SIGN_EXT_EN
  assign push_data = DATA_W'($signed(sr_q));
`else
  assign push_data = DATA_W'(sr_q);
`endif

  assign fifo_empty = (lvl_q == '0);
  assign fifo_full  = (lvl_q == LVL_W'(FIFO_DEPTH));
  assign pop        = rd_en && !fifo_empty;
  assign wr         = pend_q && (!fifo_full || pop);
  assign drop       = pend_q && fifo_full && !pop;

  always_comb begin
    wptr_d = wr  ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    lvl_d  = lvl_q;
    case ({wr, pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bclk_q    <= 1'b0;
      ws_q      <= 1'b0;
      fc_q      <= '0;
      stereo_q  <= 1'b0;
      sr_q      <= '0;
      pend_q    <= 1'b0;
      pend_ch_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      lvl_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      ws_q      <= ws_d;
      fc_q      <= fc_d;
      stereo_q  <= stereo_d;
      sr_q      <= sr_d;
      pend_q    <= pend_d;
      pend_ch_q <= pend_ch_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      lvl_q     <= lvl_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= {pend_ch_q, push_data};
  end

  assign BCLK     = bclk_q;
  assign WS       = ws_q;
  assign done     = pend_q;
  assign empty    = fifo_empty;
  assign full     = fifo_full;
  assign level    = lvl_q;
  assign overflow = ovf_q;
  assign rd_data  = fifo_empty ? '0 : mem_q[rptr_q][DATA_W-1:0];
  assign rd_ch    = !fifo_empty && mem_q[rptr_q][DATA_W];

endmodule

// File: tb/tb_i2s_rx_fifo.sv
`timescale 1ns/1ps
module tb_i2s_rx_fifo;
  localparam int CLK_DIV    = 4;
  localparam int SLOT_W     = 32;
  localparam int SAMPLE_W   = 24;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, en, stereo, DIN, rd_en, ovf_clr;
  logic WS, BCLK, done, rd_ch, empty, full, overflow;
  logic [DATA_W-1:0] rd_data;
  logic [LVL_W-1:0]  level;

  always #5 clk = ~clk;

  i2s_rx_fifo #(
    .CLK_DIV(CLK_DIV), .SLOT_W(SLOT_W), .SAMPLE_W(SAMPLE_W),
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .stereo(stereo), .WS(WS), .BCLK(BCLK),
    .DIN(DIN), .done(done), .rd_en(rd_en), .rd_data(rd_data), .rd_ch(rd_ch),
    .empty(empty), .full(full), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Free-running observers: done pulses and BCLK/WS periods in clk cycles.
  int   cyc = 0, done_cnt = 0;
  int   bclk_last = 0, bclk_per = 0, ws_last = 0, ws_per = 0;
  logic bclk_prev = 1'b0, ws_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    bclk_prev <= BCLK;
    ws_prev   <= WS;
    if (BCLK === 1'b1 && bclk_prev === 1'b0) begin
      bclk_per  <= cyc - bclk_last;
      bclk_last <= cyc;
    end
    if (WS === 1'b1 && ws_prev === 1'b0) begin
      ws_per  <= cyc - ws_last;
      ws_last <= cyc;
    end
  end

  // Reference model: ordered queue of expected FIFO entries.
  typedef struct packed {
    logic              ch;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t mq[$];
  bit   ovf_exp;
  logic [SAMPLE_W-1:0] lw[$];
  logic [SAMPLE_W-1:0] rw[$];
  int   pops_left = 0;

  function automatic logic [DATA_W-1:0] ext(input logic [SAMPLE_W-1:0] s);
`ifdef I2S_RX_SIGN_EXT_EN
    ext = {{(DATA_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
`else
    ext = {{(DATA_W-SAMPLE_W){1'b0}}, s};
`endif
  endfunction

  task automatic model_push(input logic ch, input logic [SAMPLE_W-1:0] s);
    ent_t e;
    if (mq.size() == FIFO_DEPTH) ovf_exp = 1'b1;
    else begin
      e.ch = ch;
      e.d  = ext(s);
      mq.push_back(e);
    end
  endtask

  task automatic model_frames(input int n, input bit st);
    for (int f = 0; f < n; f++) begin
      model_push(1'b0, lw[f]);
      if (st) model_push(1'b1, rw[f]);
    end
  endtask

  // One extra frame is allocated because a run ends inside frame n.
  task automatic set_frames(input int n);
    lw.delete();
    rw.delete();
    for (int f = 0; f <= n; f++) begin
      lw.push_back(SAMPLE_W'($urandom));
      rw.push_back(SAMPLE_W'($urandom));
    end
  endtask

  // Slave data for frame frm at frame position fc; unused slot bits are noise.
  function automatic logic din_bit(input int frm, input int fc);
    int idx;
    din_bit = 1'($urandom);
    if (fc >= 1 && fc <= SLOT_W) begin
      idx = fc - 1;
      if (idx < SAMPLE_W) din_bit = lw[frm][SAMPLE_W-1-idx];
    end else if (fc > SLOT_W) begin
      idx = fc - SLOT_W - 1;
      if (idx < SAMPLE_W) din_bit = rw[frm][SAMPLE_W-1-idx];
    end
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
    if (done === 1'b1 && pops_left > 0) begin
      rd_en = 1'b1;
      pops_left--;
    end else begin
      rd_en = 1'b0;
    end
  endtask

  task automatic wait_fall(output bit ok);
    logic b0;
    ok = 1'b0;
    for (int i = 0; i < 4*CLK_DIV+4; i++) begin
      b0 = BCLK;
      tick_clk();
      if (b0 === 1'b1 && BCLK === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Raise en and act as the slave until frame nfr reaches position stop_fc.
  task automatic run_frames(input int nfr, input int stop_fc);
    int fc, frm;
    bit ok;
    fc  = 0;
    frm = 0;
    @(negedge clk);
    DIN = 1'($urandom);
    en  = 1'b1;
    while (!(frm == nfr && fc == stop_fc)) begin
      wait_fall(ok);
      if (!ok) begin
        chk("bclk_fall_seen", 64'(ok), 64'd1);
        break;
      end
      fc++;
      if (fc == 2*SLOT_W) begin
        fc = 0;
        frm++;
      end
      DIN = din_bit(frm, fc);
    end
    tick_clk();
    tick_clk();
    rd_en = 1'b0;
  endtask

  task automatic stop_en();
    @(negedge clk);
    en    = 1'b0;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input int n, input string tag);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      if (mq.size() == 0) break;
      @(negedge clk);
      e = mq.pop_front();
      chk({tag, "_data"}, 64'(rd_data), 64'(e.d));
      chk({tag, "_ch"}, 64'(rd_ch), 64'(e.ch));
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bclk"}, 64'(BCLK), 64'd0);
    chk({tag, "_ws"}, 64'(WS), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_rd_ch"}, 64'(rd_ch), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1; en = 1'b0; stereo = 1'b1; DIN = 1'b0;
    rd_en = 1'b0; ovf_clr = 1'b0; ovf_exp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // Stereo, one frame with fixed patterns.
    set_frames(1);
    lw[0] = 24'hA5A5A5;
    rw[0] = 24'h5A5A5A;
    stereo = 1'b1;
    d0 = done_cnt;
    run_frames(1, 0);
    stop_en();
    model_frames(1, 1'b1);
    chk("t1_done", 64'(done_cnt - d0), 64'd2);
    chk("t1_level", 64'(level), 64'd2);
    chk("t1_bclk_per", 64'(bclk_per), 64'(2*CLK_DIV));
    drain(2, "t1");
    chk("t1_empty", 64'(empty), 64'd1);

    // Mono: three left samples, right slot ignored.
    set_frames(3);
    lw[0] = 24'h000001;
    lw[1] = 24'h000002;
    lw[2] = 24'h000003;
    stereo = 1'b0;
    d0 = done_cnt;
    run_frames(3, 0);
    stop_en();
    model_frames(3, 1'b0);
    chk("t2_done", 64'(done_cnt - d0), 64'd3);
    chk("t2_level", 64'(level), 64'd3);
    drain(3, "t2");

    // Nine random stereo frames with no reads: fill and overflow.
    set_frames(9);
    stereo = 1'b1;
    d0 = done_cnt;
    run_frames(9, 0);
    stop_en();
    model_frames(9, 1'b1);
    chk("t3_done", 64'(done_cnt - d0), 64'd18);
    chk("t3_level", 64'(level), 64'(mq.size()));
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_ovf", 64'(overflow), 64'(ovf_exp));
    chk("t3_ws_per", 64'(ws_per), 64'(2*SLOT_W*2*CLK_DIV));
    chk("t3_head", 64'(rd_data), 64'(mq[0].d));
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    ovf_exp = 1'b0;
    chk("t3_ovf_clr", 64'(overflow), 64'(ovf_exp));

    // Full FIFO, pop coincident with the next completion.
    set_frames(1);
    stereo = 1'b0;
    pops_left = 1;
    d0 = done_cnt;
    run_frames(1, 0);
    stop_en();
    void'(mq.pop_front());
    model_push(1'b0, lw[0]);
    chk("t4_done", 64'(done_cnt - d0), 64'd1);
    chk("t4_pop_used", 64'(pops_left), 64'd0);
    chk("t4_level", 64'(level), 64'd16);
    chk("t4_ovf", 64'(overflow), 64'(ovf_exp));
    chk("t4_head", 64'(rd_data), 64'(mq[0].d));
    chk("t4_head_ch", 64'(rd_ch), 64'(mq[0].ch));

    // Drain everything, then abort a frame mid left slot and restart.
    drain(16, "t5");
    @(negedge clk);
    chk("t5_empty", 64'(empty), 64'd1);
    chk("t5_empty_data", 64'(rd_data), 64'd0);
    chk("t5_empty_ch", 64'(rd_ch), 64'd0);
    set_frames(0);
    stereo = 1'b1;
    d0 = done_cnt;
    run_frames(0, 10);
    stop_en();
    chk("t5_abort_bclk", 64'(BCLK), 64'd0);
    chk("t5_abort_ws", 64'(WS), 64'd0);
    chk("t5_abort_level", 64'(level), 64'd0);
    chk("t5_abort_done", 64'(done_cnt - d0), 64'd0);
    set_frames(1);
    lw[0] = 24'h800001;
    d0 = done_cnt;
    run_frames(1, 0);
    stop_en();
    model_frames(1, 1'b1);
    chk("t5_done", 64'(done_cnt - d0), 64'd2);
    chk("t5_level", 64'(level), 64'd2);
    drain(2, "t5b");

    // Overflow again, then synchronous reset in the middle of a frame.
    set_frames(9);
    stereo = 1'b1;
    run_frames(9, 20);
    chk("t6_full_pre", 64'(full), 64'd1);
    chk("t6_ovf_pre", 64'(overflow), 64'd1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_rst");
    en = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("t6_level_after", 64'(level), 64'd0);
    mq.delete();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
